// File: rtl/fluxo_dados_n.sv
// fluxo_dados_n: parametrised game datapath driven by the game control unit.
//
// Holds the colour sequence memory, the address/limit counters, the jogada
// register, the play-timeout and LED timers, the lives and score counters,
// the mode register and a free-running LFSR used to generate random entries.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   zera_*/conta_*/enable_*      counter and timer clear / advance commands
//   zeraR, registrarR            jogada register clear / load (from botoes)
//   zera_modo, registra_modo     config register clear / load (from configuracao)
//   registra_jogada, gera_jogada write botoes / random colour at endereco
//   conf_leds                    show memory colour on leds
//   zera_vidas, perde_vida       reload / decrement lives
//   acerto                       increment score
//   botoes [N_BOTOES]            player buttons
//   configuracao [3]             {fonte aleatoria, timeout habilitado, modo demo}
//   igual, fim_jogo, enderecoIgualLimite, fim_sequencia   compare flags
//   jogada_feita, jogada_valida  button press pulse / one-hot buttons
//   timeout, timeout_led         timer terminal flags
//   timeout_habilitado, fonte_aleatoria, sem_vidas        status
//   leds [N_BOTOES], pontos [ADDR_W+1], vidas [3]          game outputs
//   db_contagem, db_limite, db_memoria, db_jogada          debug taps

// Saturating up-counter timer; done stays high at the terminal count until
// cleared.
module fluxo_timer #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic en,
    output logic done
);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || zera)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == LAST);
endmodule

module fluxo_dados_n #(
    parameter int          N_BOTOES     = 4,
    parameter int          ADDR_W       = 4,
    parameter int          RODADAS_DEMO = 4,
    parameter int          TIMEOUT_M    = 5000,
    parameter int          LED_M        = 2000,
    parameter int          VIDAS        = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                zera_endereco,
    input  logic                conta_endereco,
    input  logic                zera_limite,
    input  logic                conta_limite,
    input  logic                zeraR,
    input  logic                registrarR,
    input  logic                zera_s_timeout,
    input  logic                enable_timeout,
    input  logic                zera_s_led,
    input  logic                enable_led,
    input  logic                zera_modo,
    input  logic                registra_modo,
    input  logic                registra_jogada,
    input  logic                gera_jogada,
    input  logic                conf_leds,
    input  logic                zera_vidas,
    input  logic                perde_vida,
    input  logic                acerto,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic [2:0]          configuracao,
    output logic                igual,
    output logic                fim_jogo,
    output logic                enderecoIgualLimite,
    output logic                fim_sequencia,
    output logic                jogada_feita,
    output logic                jogada_valida,
    output logic                timeout,
    output logic                timeout_led,
    output logic                timeout_habilitado,
    output logic                fonte_aleatoria,
    output logic                sem_vidas,
    output logic [N_BOTOES-1:0] leds,
    output logic [ADDR_W:0]     pontos,
    output logic [2:0]          vidas,
    output logic [ADDR_W-1:0]   db_contagem,
    output logic [ADDR_W-1:0]   db_limite,
    output logic [N_BOTOES-1:0] db_memoria,
    output logic [N_BOTOES-1:0] db_jogada
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] LIM_DEMO = ADDR_W'(RODADAS_DEMO - 1);

    logic [ADDR_W-1:0]                endereco, limite, lim_jogo;
    logic [N_BOTOES-1:0]              jogada_r, mem_rd, cor_lfsr;
    logic [DEPTH-1:0][N_BOTOES-1:0]   mem;
    logic [2:0]                       cfg;
    logic [15:0]                      lfsr;
    logic [7:0]                       cor_idx;
    logic                             ativo_q;

    // ---------------- counters ----------------
    always_ff @(posedge clock) begin
        if (reset || zera_endereco)
            endereco <= '0;
        else if (conta_endereco)
            endereco <= endereco + 1'b1;   // natural wrap
    end

    always_ff @(posedge clock) begin
        if (reset || zera_limite)
            limite <= '0;
        else if (conta_limite && limite != ADDR_MAX)
            limite <= limite + 1'b1;
    end

    // ---------------- config / jogada registers ----------------
    always_ff @(posedge clock) begin
        if (reset || zera_modo)
            cfg <= '0;
        else if (registra_modo)
            cfg <= configuracao;
    end

    always_ff @(posedge clock) begin
        if (reset || zeraR)
            jogada_r <= '0;
        else if (registrarR)
            jogada_r <= botoes;
    end

    // ---------------- LFSR colour source ----------------
    // Fibonacci, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    always_ff @(posedge clock) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        cor_idx  = lfsr[7:0] % 8'(N_BOTOES);
        cor_lfsr = '0;
        for (int i = 0; i < N_BOTOES; i++)
            cor_lfsr[i] = (cor_idx == 8'(i));
    end

    // ---------------- sequence memory ----------------
    // A registra_jogada with an invalid (non one-hot) pattern still blocks
    // gera_jogada: the player write owns the cycle even when dropped.
    always_ff @(posedge clock) begin
        if (reset)
            mem <= '0;
        else if (registra_jogada) begin
            if (jogada_valida)
                mem[endereco] <= botoes;
        end else if (gera_jogada)
            mem[endereco] <= cor_lfsr;
    end

    assign mem_rd = mem[endereco];

    // ---------------- button press detection ----------------
    // Pulse is registered, so it appears the cycle after the edge that first
    // samples a nonzero botoes.
    always_ff @(posedge clock) begin
        if (reset) begin
            ativo_q      <= 1'b0;
            jogada_feita <= 1'b0;
        end else begin
            ativo_q      <= |botoes;
            jogada_feita <= (|botoes) & ~ativo_q;
        end
    end

    assign jogada_valida = (botoes != '0) && ((botoes & (botoes - 1'b1)) == '0);

    // ---------------- timers ----------------
    fluxo_timer #(.M(TIMEOUT_M)) u_tmr_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_s_timeout),
        .en    (enable_timeout && timeout_habilitado),
        .done  (timeout)
    );

    fluxo_timer #(.M(LED_M)) u_tmr_led (
        .clock (clock),
        .reset (reset),
        .zera  (zera_s_led),
        .en    (enable_led),
        .done  (timeout_led)
    );

    // ---------------- lives / score ----------------
    always_ff @(posedge clock) begin
        if (reset || zera_vidas)
            vidas <= 3'(VIDAS);
        else if (perde_vida && vidas != 3'd0)
            vidas <= vidas - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            pontos <= '0;
        else if (acerto && pontos != '1)
            pontos <= pontos + 1'b1;
    end

    // ---------------- flags and outputs ----------------
    assign lim_jogo            = cfg[0] ? LIM_DEMO : ADDR_MAX;
    assign fim_jogo            = (limite == lim_jogo);
    assign enderecoIgualLimite = (endereco == limite);
    assign fim_sequencia       = enderecoIgualLimite;
    assign igual               = (mem_rd == jogada_r);
    assign timeout_habilitado  = cfg[1];
    assign fonte_aleatoria     = cfg[2];
    assign sem_vidas           = (vidas == 3'd0);
    assign leds                = conf_leds ? mem_rd : '0;
    assign db_contagem         = endereco;
    assign db_limite           = limite;
    assign db_memoria          = mem_rd;
    assign db_jogada           = jogada_r;
endmodule

// File: doc/fluxo_dados_n.md
Name: fluxo_dados_n

Overview:
- Parametrised successor of the game datapath: sequence memory, address/limit counters, comparators, timeout and LED timers, and mode registers, all driven by the game control unit.
- Generalised in button count, sequence depth and timer lengths.
- New features: LFSR-generated sequence entries, lives counter, saturating score counter, one-hot jogada validation.
- Drives a one-hot colour bus instead of RGB.

Parameters:
N_BOTOES, 4, number of buttons/colours (2..8); sequence entries are one-hot N_BOTOES bits
ADDR_W, 4, address width; sequence depth 2^ADDR_W
RODADAS_DEMO, 4, rounds in demo mode (1..2^ADDR_W)
TIMEOUT_M, 5000, play-timeout length in cycles
LED_M, 2000, LED-display length in cycles
VIDAS, 3, lives loaded at reset/zera_vidas (1..7)
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
zera_endereco, conta_endereco  in  1  address counter clear/increment
zera_limite, conta_limite  in  1  limit counter clear/increment
zeraR, registrarR  in  1  jogada register clear/load
zera_s_timeout, enable_timeout  in  1  timeout timer clear/count
zera_s_led, enable_led  in  1  LED timer clear/count
zera_modo, registra_modo  in  1  config register clear/load
registra_jogada  in  1  write botoes into memory at endereco
gera_jogada  in  1  write LFSR colour into memory at endereco
conf_leds  in  1  1 = show memory colour on leds, 0 = dark
zera_vidas, perde_vida  in  1  reload lives / decrement lives
acerto  in  1  increment score
botoes  in  N_BOTOES  player buttons
configuracao  in  3  [0] modo (1 = demo), [1] timeout enabled, [2] random source
igual, fim_jogo, enderecoIgualLimite, fim_sequencia  out  1  compare flags
jogada_feita, jogada_valida  out  1  button rising-edge pulse; botoes is one-hot
timeout, timeout_led  out  1  timer terminal flags
timeout_habilitado, fonte_aleatoria, sem_vidas  out  1  status
leds  out  N_BOTOES  gated colour
pontos  out  ADDR_W+1  score
vidas  out  3  remaining lives
db_contagem, db_limite  out  ADDR_W  debug
db_memoria, db_jogada  out  N_BOTOES  debug

Behaviour:
- Reset (synchronous, overrides all commands):
  - endereco, limite, jogada register, timers, pontos, config registers, memory and edge-detector history all cleared to 0.
  - vidas = VIDAS; LFSR = LFSR_SEED.
  - Every output therefore takes its reset-derived value: leds = 0, timeouts = 0, jogada_feita = 0.
- Address counter:
  - Zero takes priority over count.
  - Wraps 2^ADDR_W-1 -> 0.
- Limit counter:
  - Zero takes priority over count.
  - Saturates at 2^ADDR_W-1.
- Derived flags:
  - enderecoIgualLimite = fim_sequencia = (endereco == limite).
  - fim_jogo = (limite == lim_jogo), where lim_jogo = modo ? RODADAS_DEMO-1 : 2^ADDR_W-1.
- Memory: 2^ADDR_W x N_BOTOES register array; combinational read at endereco.
  - registra_jogada writes botoes only when jogada_valida; otherwise the write is dropped.
  - gera_jogada writes one-hot(lfsr[7:0] % N_BOTOES).
  - Both asserted: registra_jogada wins.
  - Read of an address being written returns the old value until the next cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
- Jogada validation and detection:
  - igual = (memoria[endereco] == jogada register).
  - jogada_valida = botoes has exactly one bit set (combinational).
  - jogada_feita = one-cycle pulse on the 0 -> nonzero transition of |botoes, one cycle after the transition is sampled.
- Timeout timer:
  - Counts only when enable_timeout && timeout_habilitado.
  - Saturates at TIMEOUT_M-1; timeout = (count == TIMEOUT_M-1) and stays high until zera_s_timeout.
  - zera_s_timeout has priority over enable.
- LED timer: same rules with LED_M, enable_led, zera_s_led; independent of timeout_habilitado.
- Lives counter:
  - zera_vidas reloads VIDAS and has priority over perde_vida.
  - perde_vida at 0 holds 0.
  - sem_vidas = (vidas == 0).
- Score: acerto increments pontos, saturating at 2^(ADDR_W+1)-1.
- leds = conf_leds ? memoria[endereco] : 0.
- Config register: loads configuracao on registra_modo; zera_modo clears it (priority over load). Changing configuracao without a load has no effect.

Test Plan:
- Reset with all commands active -> next cycle endereco=0, limite=0, vidas=3, pontos=0, leds=0, timeout=0.
- registra_jogada, botoes=4'b0100 at addr 2; conf_leds=1 -> leds=4'b0100. Write botoes=4'b0110 at addr 3 -> memoria[3] stays 0, jogada_valida=0.
- Config 3'b101, gera_jogada at addrs 0..3 -> every entry one-hot. fonte_aleatoria=1. conta_limite x3 -> fim_jogo=1 at limite=3 (demo).
- Config timeout_hab=0, enable_timeout held 6000 cycles -> timeout=0. With hab=1 -> timeout rises exactly 4999 cycles after enable, holds, clears on zera_s_timeout.
- perde_vida x4 -> vidas 2,1,0,0 and sem_vidas=1 after the third. Then zera_vidas+perde_vida in the same cycle -> vidas=3.
- botoes 0 -> 0001 held 5 cycles -> jogada_feita high for exactly one cycle. conta_endereco at 15 -> 0; conta_limite at 15 stays 15.
